// File: rtl/array_incr_resp.sv
// Collects DEPTH elements into a frame buffer, then emits each element plus one in order.
// Define ARRAY_SAT_EN to make the increment saturate at the all-ones value instead of wrapping.
module array_incr_resp #(
    parameter int DEPTH = 5,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic [15:0]      frame_cnt
);

    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] EMIT    = 1'b1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic [0:0]       state;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [WIDTH-1:0] buffer [DEPTH];
    logic [WIDTH-1:0] rd_elem;
    logic [WIDTH-1:0] incr;
    logic             in_fire;
    logic             out_fire;

    // The phases never overlap, so both handshake qualifiers come straight from the state.
    assign in_ready  = (state == COLLECT);
    assign out_valid = (state == EMIT);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    assign rd_elem = buffer[rd_idx];

`ifdef ARRAY_SAT_EN
    assign incr = (rd_elem == {WIDTH{1'b1}}) ? rd_elem : rd_elem + WIDTH'(1);
`else
    assign incr = rd_elem + WIDTH'(1);
`endif

    // Outputs are forced to zero outside EMIT so they read as cleared straight after reset.
    assign out_data = out_valid ? incr : '0;
    assign out_last = out_valid && (rd_idx == LAST_IDX);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= COLLECT;
            wr_idx    <= '0;
            rd_idx    <= '0;
            frame_cnt <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (in_fire) begin
                        if (wr_idx == LAST_IDX) begin
                            wr_idx <= '0;
                            state  <= EMIT;
                        end else begin
                            wr_idx <= wr_idx + IDX_W'(1);
                        end
                    end
                end
                EMIT: begin
                    if (out_fire) begin
                        if (out_last) begin
                            rd_idx    <= '0;
                            state     <= COLLECT;
                            frame_cnt <= frame_cnt + 16'd1;
                        end else begin
                            rd_idx <= rd_idx + IDX_W'(1);
                        end
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

    // NOTE: the frame buffer has no reset; every slot is rewritten before EMIT can read it.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            buffer[wr_idx] <= in_data;
        end
    end

endmodule

// File: tb/tb_array_incr_resp.sv
// Directed self-checking bench for array_incr_resp (DEPTH=5, WIDTH=8).
// Expected results are hand-computed; ARRAY_SAT_EN selects the saturating expectations.
module tb_array_incr_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic [15:0] frame_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc_cnt  = 0;
    int t_first  = 0;
    int t_last   = 0;

    logic [7:0] vin  [5];
    logic [7:0] vexp [5];
    logic [7:0] got  [5];
    logic       gotl [5];

    array_incr_resp #(.DEPTH(5), .WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Offers vin[0..cnt-1]; vmask bit (cycle mod 16) decides whether in_valid is raised that cycle.
    task automatic fill(input int cnt, input logic [15:0] vmask);
        int   i = 0;
        int   c = 0;
        logic rdy;
        while (i < cnt && c < 64) begin
            in_valid = vmask[c % 16];
            in_data  = in_valid ? vin[i] : 8'hC3;
            rdy      = in_ready;
            @(posedge clk);
            #1;
            if (in_valid && rdy) begin
                if (i == 0) t_first = cyc_cnt;
                i++;
            end
            c++;
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
        check("fill_count", i, cnt);
    endtask

    // Drains one frame with out_ready following rmask; optionally offers junk input throughout.
    task automatic drain(input logic [15:0] rmask, input logic junk);
        int         n = 0;
        int         c = 0;
        logic [7:0] pd = 8'h00;
        logic       pl = 1'b0;
        logic       stalled = 1'b0;
        logic       fire;
        check("first_valid", out_valid, 1);
        while (n < 5 && c < 64) begin
            out_ready = rmask[c % 16];
            in_valid  = junk;
            in_data   = 8'hEE;
            #1;
            check("emit_in_ready", in_ready, 0);
            if (stalled) begin
                check("stall_data", out_data, pd);
                check("stall_last", out_last, pl);
            end
            fire = out_valid && out_ready;
            if (fire) begin
                got[n]  = out_data;
                gotl[n] = out_last;
                n++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                pd      = out_data;
                pl      = out_last;
            end
            @(posedge clk);
            #1;
            if (fire && n == 5) t_last = cyc_cnt;
            c++;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("drain_count", n, 5);
        for (int k = 0; k < 5; k++) begin
            check("out_data", got[k], vexp[k]);
            check("out_last", gotl[k], (k == 4) ? 1 : 0);
        end
    endtask

    task automatic set_frame(input logic [39:0] ins, input logic [39:0] exps);
        for (int k = 0; k < 5; k++) begin
            vin[k]  = ins[8*(4-k) +: 8];
            vexp[k] = exps[8*(4-k) +: 8];
        end
    endtask

    task automatic idle_checks(input logic [15:0] cnt_exp);
        check("idle_in_ready", in_ready, 1);
        check("idle_out_valid", out_valid, 0);
        check("idle_out_last", out_last, 0);
        check("idle_frame_cnt", frame_cnt, cnt_exp);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle_checks(16'd0);
        check("reset_out_data", out_data, 0);

        // Basic frame, back-to-back: 10 cycles from first accept to last emit.
        set_frame(40'h10_20_30_40_50, 40'h11_21_31_41_51);
        fill(5, 16'hFFFF);
        drain(16'hFFFF, 1'b0);
        check("frame_cycles", t_last - t_first, 9);
        idle_checks(16'd1);

        // Increment wrap or saturation at the element boundaries.
`ifdef ARRAY_SAT_EN
        set_frame(40'hFF_00_7F_FE_FF, 40'hFF_01_80_FF_FF);
`else
        set_frame(40'hFF_00_7F_FE_FF, 40'h00_01_80_FF_00);
`endif
        fill(5, 16'hFFFF);
        drain(16'hFFFF, 1'b0);
        idle_checks(16'd2);

        // Backpressure 1,0,0,1,... with junk offered on the input during EMIT.
        set_frame(40'h01_02_03_04_05, 40'h02_03_04_05_06);
        fill(5, 16'hFFFF);
        drain(16'h9999, 1'b1);
        idle_checks(16'd3);

        // Gappy input valid; contents must be unaffected by the earlier junk.
        set_frame(40'h80_81_82_83_84, 40'h81_82_83_84_85);
        fill(5, 16'hA5C3);
        drain(16'hFFFF, 1'b0);
        idle_checks(16'd4);

        // Reset after three accepted inputs discards the partial frame.
        set_frame(40'h90_91_92_93_94, 40'h00_00_00_00_00);
        fill(3, 16'hFFFF);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_checks(16'd0);
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_out_valid", out_valid, 0);
        set_frame(40'h01_02_03_04_05, 40'h02_03_04_05_06);
        fill(5, 16'hFFFF);
        drain(16'hFFFF, 1'b0);
        idle_checks(16'd1);

        // Reset mid-EMIT wins over a simultaneous output handshake.
        set_frame(40'h30_31_32_33_34, 40'h31_32_33_34_35);
        fill(5, 16'hFFFF);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b0;
        idle_checks(16'd0);
        check("emit_rst_out_data", out_data, 0);

        // Counter wrap: preload near the top rather than streaming 65534 frames.
        force dut.frame_cnt = 16'hFFFE;
        #1;
        release dut.frame_cnt;
        set_frame(40'hA0_A1_A2_A3_A4, 40'hA1_A2_A3_A4_A5);
        fill(5, 16'hFFFF);
        drain(16'hFFFF, 1'b0);
        check("cnt_ffff", frame_cnt, 16'hFFFF);
        fill(5, 16'hFFFF);
        drain(16'hFFFF, 1'b0);
        check("cnt_wrap", frame_cnt, 16'h0000);
        fill(5, 16'hFFFF);
        drain(16'hFFFF, 1'b0);
        check("cnt_after_wrap", frame_cnt, 16'h0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/array_incr_resp.md
ARRAY_INCR_RESP -- requirements
Module: array_incr_resp

Interface
REQ-001 SHALL provide parameter DEPTH, default 5, giving the number of elements per array frame (legal range 2..16).
REQ-002 SHALL provide parameter WIDTH, default 8, giving the element width in bits.
REQ-003 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port in_valid, input, 1: in_data holds a valid element.
REQ-006 Port in_ready, output, 1: block accepts an element this cycle.
REQ-007 Port in_data, input, WIDTH: inbound array element.
REQ-008 Port out_valid, output, 1: out_data holds a valid result element.
REQ-009 Port out_ready, input, 1: downstream accepts out_data this cycle.
REQ-010 Port out_data, output, WIDTH: result element, input element + 1.
REQ-011 Port out_last, output, 1: out_data is the final element of the frame (index DEPTH-1).
REQ-012 Port frame_cnt, output, 16: count of completely emitted frames.

Function
REQ-013 SHALL implement a two-state FSM, COLLECT and EMIT; reset state is COLLECT.
REQ-014 COLLECT: in_ready=1, out_valid=0; on in_valid&&in_ready, store in_data in buffer[wr_idx] and increment wr_idx.
REQ-015 COLLECT->EMIT: on the cycle the element with wr_idx==DEPTH-1 is accepted; wr_idx returns to 0.
REQ-016 EMIT: in_ready=0, out_valid=1, out_data=f(buffer[rd_idx]), out_last=(rd_idx==DEPTH-1).
REQ-017 EMIT: on out_valid&&out_ready, increment rd_idx; out_data/out_last stay stable while out_ready=0.
REQ-018 EMIT->COLLECT: on handshake with out_last=1; rd_idx returns to 0, frame_cnt increments by 1 that same edge.
REQ-019 Latency: first out_valid asserted the cycle after the last input element is accepted; no overlap of collect and emit (in_ready=0 throughout EMIT).
REQ-020 Throughput: one element per cycle in each phase when the peer holds valid/ready high; a frame takes exactly 2*DEPTH cycles.
REQ-021 Arithmetic: f(x)=(x+1) mod 2^WIDTH unless ARRAY_SAT_EN is defined (REQ-028).
REQ-022 frame_cnt wraps 0xFFFF->0x0000 without side effects.
REQ-023 in_valid with in_ready=0 SHALL be ignored; the element is not stored and no state changes.
REQ-024 in_data is sampled only on handshake; values while in_valid=0 have no effect.
REQ-025 Element order: out element i SHALL correspond to the input element i of the same frame.

Reset
REQ-026 rst=1 at a clock edge: state=COLLECT, wr_idx=0, rd_idx=0, frame_cnt=0, out_valid=0, out_last=0, out_data=0, in_ready=1 from the next cycle; buffer contents need not be cleared.
REQ-027 rst asserted mid-COLLECT or mid-EMIT SHALL discard the partial frame and not increment frame_cnt; rst has priority over any simultaneous handshake.

Configuration
REQ-028 Macro ARRAY_SAT_EN: defined -> f(x)=x+1 saturating at 2^WIDTH-1 (0xFF->0xFF); undefined -> wrapping (0xFF->0x00). No other behaviour differs.

Verification
REQ-029 Basic frame: inputs 0x10,0x20,0x30,0x40,0x50, out_ready=1 -> outputs 0x11,0x21,0x31,0x41,0x51, out_last on the 5th, frame_cnt 0->1, total 10 cycles.
REQ-030 Wrap/saturate: input 0xFF,0x00,0x7F,0xFE,0xFF -> 0x00,0x01,0x80,0xFF,0x00 without ARRAY_SAT_EN; 0xFF,0x01,0x80,0xFF,0xFF with it.
REQ-031 Backpressure: out_ready toggled 1,0,0,1,... during EMIT -> out_data/out_last stable while stalled, no element lost or duplicated, in_ready=0 until the last handshake.
REQ-032 Input gaps: in_valid random 50% during COLLECT -> exactly 5 elements stored, in_valid during EMIT ignored (no change to next frame contents).
REQ-033 Reset mid-frame: rst pulsed after 3 inputs accepted -> out_valid stays 0, frame_cnt=0, next 5 inputs 1..5 produce 2..6.
REQ-034 Counter wrap: 65536 back-to-back frames -> frame_cnt reads 0 after the last, 1 after one more.
